// File: rtl/regbank_arb_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding, requester
// indices, bank widths and the round-robin successor helper.
package regbank_arb_pkg;

    localparam int REG_SEL_W  = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_SEL_W-1:0]  reg_sel_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [1:0] REQ_RD  = 2'd0;
    localparam logic [1:0] REQ_WR0 = 2'd1;
    localparam logic [1:0] REQ_WR1 = 2'd2;

    // Next requester in the rd -> wr0 -> wr1 -> rd ring.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_WR1) ? REQ_RD : idx + 2'd1;
    endfunction

endpackage

// File: rtl/regbank_arb_rr_arb3.sv
// Three-way round-robin arbiter: combinational grant, registered pointer to
// the last granted requester; the search starts just after that pointer.
module rr_arb3
    import regbank_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetBar,
    input  logic [2:0] req,
    input  logic       take,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       any
);

    logic [1:0] last_reg;
    logic [1:0] cand;

    always_comb begin
        any       = 1'b0;
        grant_idx = REQ_RD;
        cand      = rr_next(last_reg);
        for (int k = 0; k < 3; k++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
            cand = rr_next(cand);
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_grant
            assign grant[gi] = any && (grant_idx == 2'(gi));
        end
    endgenerate

    // Reset to wr1 so that rd is the first requester searched.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            last_reg <= REQ_WR1;
        end else if (take && any) begin
            last_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/regbank_arb.sv
// Register-bank port arbiter: one read port and two write ports share a
// single-ported bank, one access every two cycles, all outputs registered.
module regbank_arb
    import regbank_arb_pkg::*;
(
    input  logic        clk,
    input  logic        resetBar,
    input  logic        rdReq,
    input  logic [4:0]  rdSel0,
    input  logic [4:0]  rdSel1,
    output logic        rdAck,
    output logic        rdValid,
    output logic [31:0] rdData0,
    output logic [31:0] rdData1,
    input  logic        wr0Req,
    input  logic [4:0]  wr0Sel,
    input  logic [31:0] wr0Data,
    output logic        wr0Ack,
    input  logic        wr1Req,
    input  logic [4:0]  wr1Sel,
    input  logic [31:0] wr1Data,
    output logic        wr1Ack,
    output logic [4:0]  regSelSrc0,
    output logic [4:0]  regSelSrc1,
    output logic [4:0]  regSelDst,
    output logic [31:0] regDst,
    input  logic [31:0] regSrc0,
    input  logic [31:0] regSrc1,
    output logic        CSBar,
    output logic        RDWRBar
);

    logic [0:0] state_reg;
    logic       is_read_reg;
    logic [2:0] ack_reg;
    logic       cs_bar_reg;
    logic       rdwr_bar_reg;
    logic       rd_valid_reg;
    reg_sel_t   src_sel_reg [2];
    reg_sel_t   dst_sel_reg;
    reg_data_t  dst_data_reg;
    reg_data_t  rd_data_reg [2];
    reg_data_t  src_bus     [2];

    logic [2:0] req_vec;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       grant_any;
    logic       in_idle;

    assign req_vec = {wr1Req, wr0Req, rdReq};
    assign in_idle = (state_reg == ST_IDLE);

    rr_arb3 u_rr_arb3 (
        .clk       (clk),
        .resetBar  (resetBar),
        .req       (req_vec),
        .take      (in_idle),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // The grant cycle loads every bank-facing register for the ACCESS cycle,
    // so nothing on the bank side is combinational from the request inputs.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_reg      <= ST_IDLE;
            is_read_reg    <= 1'b0;
            ack_reg        <= 3'b000;
            cs_bar_reg     <= 1'b1;
            rdwr_bar_reg   <= 1'b1;
            rd_valid_reg   <= 1'b0;
            src_sel_reg[0] <= '0;
            src_sel_reg[1] <= '0;
            dst_sel_reg    <= '0;
            dst_data_reg   <= '0;
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_reg   <= ST_ACCESS;
                        ack_reg     <= grant;
                        is_read_reg <= (grant_idx == REQ_RD);
                        case (grant_idx)
                            REQ_RD: begin
                                src_sel_reg[0] <= rdSel0;
                                src_sel_reg[1] <= rdSel1;
                                cs_bar_reg     <= 1'b0;
                                rdwr_bar_reg   <= 1'b1;
                            end
                            REQ_WR0: begin
                                dst_sel_reg  <= wr0Sel;
                                dst_data_reg <= wr0Data;
                                cs_bar_reg   <= (wr0Sel == '0);
                                rdwr_bar_reg <= 1'b0;
                            end
                            REQ_WR1: begin
                                dst_sel_reg  <= wr1Sel;
                                dst_data_reg <= wr1Data;
                                cs_bar_reg   <= (wr1Sel == '0);
                                rdwr_bar_reg <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ACCESS: begin
                    state_reg    <= ST_IDLE;
                    ack_reg      <= 3'b000;
                    cs_bar_reg   <= 1'b1;
                    rdwr_bar_reg <= 1'b1;
                    rd_valid_reg <= is_read_reg;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign src_bus[0] = regSrc0;
    assign src_bus[1] = regSrc1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_lane
            always_ff @(posedge clk or negedge resetBar) begin
                if (!resetBar) begin
                    rd_data_reg[gi] <= '0;
                end else if (state_reg == ST_ACCESS && is_read_reg) begin
                    rd_data_reg[gi] <= src_bus[gi];
                end
            end
        end
    endgenerate

    assign rdAck      = ack_reg[REQ_RD];
    assign wr0Ack     = ack_reg[REQ_WR0];
    assign wr1Ack     = ack_reg[REQ_WR1];
    assign rdValid    = rd_valid_reg;
    assign rdData0    = rd_data_reg[0];
    assign rdData1    = rd_data_reg[1];
    assign regSelSrc0 = src_sel_reg[0];
    assign regSelSrc1 = src_sel_reg[1];
    assign regSelDst  = dst_sel_reg;
    assign regDst     = dst_data_reg;
    assign CSBar      = cs_bar_reg;
    assign RDWRBar    = rdwr_bar_reg;

endmodule

// File: tb/tb_regbank_arb.sv
// Scoreboard bench for regbank_arb: directed requests push expected accesses
// and read results; a negedge monitor pops and compares them.
module tb_regbank_arb;

    logic        clk = 1'b0;
    logic        resetBar;
    logic        rdReq, wr0Req, wr1Req;
    logic [4:0]  rdSel0, rdSel1, wr0Sel, wr1Sel;
    logic [31:0] wr0Data, wr1Data;
    logic        rdAck, rdValid, wr0Ack, wr1Ack;
    logic [31:0] rdData0, rdData1;
    logic [4:0]  regSelSrc0, regSelSrc1, regSelDst;
    logic [31:0] regDst, regSrc0, regSrc1;
    logic        CSBar, RDWRBar;

    always #5 clk = ~clk;

    regbank_arb dut (
        .clk(clk), .resetBar(resetBar),
        .rdReq(rdReq), .rdSel0(rdSel0), .rdSel1(rdSel1),
        .rdAck(rdAck), .rdValid(rdValid), .rdData0(rdData0), .rdData1(rdData1),
        .wr0Req(wr0Req), .wr0Sel(wr0Sel), .wr0Data(wr0Data), .wr0Ack(wr0Ack),
        .wr1Req(wr1Req), .wr1Sel(wr1Sel), .wr1Data(wr1Data), .wr1Ack(wr1Ack),
        .regSelSrc0(regSelSrc0), .regSelSrc1(regSelSrc1), .regSelDst(regSelDst),
        .regDst(regDst), .regSrc0(regSrc0), .regSrc1(regSrc1),
        .CSBar(CSBar), .RDWRBar(RDWRBar)
    );

    // Bank model: writes on any selected write cycle, so a stray x0 write shows up.
    logic [31:0] mem [32];
    logic        bank_init_n;
    always @(posedge clk) begin
        if (!bank_init_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (!CSBar && !RDWRBar) begin
            mem[regSelDst] <= regDst;
        end
    end
    assign regSrc0 = mem[regSelSrc0];
    assign regSrc1 = mem[regSelSrc1];

    typedef struct {
        int          kind;
        logic        cs;
        logic        rdwr;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [4:0]  dst;
        logic [31:0] d;
    } acc_t;
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
    } rdv_t;

    acc_t acc_q[$];
    rdv_t rdv_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   ack_count  = 0;
    logic burst_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    task automatic push_rd(input logic [4:0] s0, input logic [4:0] s1,
                           input logic [31:0] d0, input logic [31:0] d1);
        acc_t e;
        rdv_t r;
        e.kind = 0; e.cs = 1'b0; e.rdwr = 1'b1; e.s0 = s0; e.s1 = s1;
        e.dst = 5'd0; e.d = 32'h0;
        r.d0 = d0; r.d1 = d1;
        acc_q.push_back(e);
        rdv_q.push_back(r);
    endtask

    task automatic push_wr(input int kind, input logic [4:0] dst,
                           input logic [31:0] d, input logic cs);
        acc_t e;
        e.kind = kind; e.cs = cs; e.rdwr = 1'b0; e.s0 = 5'd0; e.s1 = 5'd0;
        e.dst = dst; e.d = d;
        acc_q.push_back(e);
    endtask

    int   cyc = 0;
    int   last_ack_cyc = -100;
    int   burst_acks = 0;
    logic prev_cs_low = 1'b0;
    logic prev_rdack  = 1'b0;

    always @(negedge clk) begin
        logic [2:0] acks;
        acc_t       e;
        rdv_t       r;
        int         kind;
        cyc++;
        acks = {wr1Ack, wr0Ack, rdAck};
        if (!burst_mode) burst_acks = 0;
        if (acks != 3'b000) begin
            chk("ack_onehot", 32'($countones(acks)), 32'd1);
            chk("ack_gap_ge2", 32'((cyc - last_ack_cyc) >= 2), 32'd1);
            if (burst_mode && burst_acks > 0)
                chk("burst_spacing", 32'(cyc - last_ack_cyc), 32'd2);
            if (acc_q.size() == 0) begin
                fail_now("unexpected_ack");
            end else begin
                e = acc_q.pop_front();
                kind = rdAck ? 0 : (wr0Ack ? 1 : 2);
                chk("grant_kind", 32'(kind), 32'(e.kind));
                chk("csbar", 32'(CSBar), 32'(e.cs));
                chk("rdwrbar", 32'(RDWRBar), 32'(e.rdwr));
                if (e.kind == 0) begin
                    chk("sel_src0", 32'(regSelSrc0), 32'(e.s0));
                    chk("sel_src1", 32'(regSelSrc1), 32'(e.s1));
                end else begin
                    chk("sel_dst", 32'(regSelDst), 32'(e.dst));
                    chk("reg_dst", regDst, e.d);
                end
            end
            ack_count++;
            burst_acks++;
            last_ack_cyc = cyc;
        end else begin
            if (!CSBar) fail_now("csbar_low_without_access");
            if (!RDWRBar) fail_now("rdwrbar_low_outside_access");
        end
        if (!CSBar && prev_cs_low) fail_now("csbar_consecutive");
        if (rdValid) begin
            chk("rdvalid_after_rdack", 32'(prev_rdack), 32'd1);
            if (rdv_q.size() == 0) begin
                fail_now("unexpected_rdvalid");
            end else begin
                r = rdv_q.pop_front();
                chk("rd_data0", rdData0, r.d0);
                chk("rd_data1", rdData1, r.d1);
            end
        end
        prev_cs_low = !CSBar;
        prev_rdack  = rdAck;
    end

    // Hold each raised request until its ack is seen, then drop it and drain.
    task automatic serve(input int budget);
        int n = 0;
        while ((rdReq || wr0Req || wr1Req) && n < budget) begin
            @(negedge clk);
            if (rdAck)  rdReq  = 1'b0;
            if (wr0Ack) wr0Req = 1'b0;
            if (wr1Ack) wr1Req = 1'b0;
            n++;
        end
        if (rdReq || wr0Req || wr1Req) begin
            fail_now("serve_timeout");
            rdReq = 1'b0; wr0Req = 1'b0; wr1Req = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        resetBar = 1'b0; bank_init_n = 1'b0;
        rdReq = 1'b0; wr0Req = 1'b0; wr1Req = 1'b0;
        rdSel0 = 5'd0; rdSel1 = 5'd0; wr0Sel = 5'd0; wr1Sel = 5'd0;
        wr0Data = 32'h0; wr1Data = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_csbar", 32'(CSBar), 32'd1);
        chk("rst_rdwrbar", 32'(RDWRBar), 32'd1);
        chk("rst_acks", 32'({wr1Ack, wr0Ack, rdAck}), 32'd0);
        chk("rst_rdvalid", 32'(rdValid), 32'd0);
        chk("rst_sels", 32'({regSelSrc0, regSelSrc1, regSelDst}), 32'd0);
        chk("rst_regdst", regDst, 32'h0);
        chk("rst_rddata0", rdData0, 32'h0);
        chk("rst_rddata1", rdData1, 32'h0);
        bank_init_n = 1'b1;
        resetBar = 1'b1;
        @(negedge clk);

        // wr0 write of reg 5
        push_wr(1, 5'd5, 32'hFAEAFAEA, 1'b0);
        wr0Sel = 5'd5; wr0Data = 32'hFAEAFAEA; wr0Req = 1'b1;
        serve(20);

        // read back reg 5 and reg 0
        push_rd(5'd5, 5'd0, 32'hFAEAFAEA, 32'h0);
        rdSel0 = 5'd5; rdSel1 = 5'd0; rdReq = 1'b1;
        serve(20);

        // wr1 to reg 0: acked, bank not selected
        push_wr(2, 5'd0, 32'h12345678, 1'b1);
        wr1Sel = 5'd0; wr1Data = 32'h12345678; wr1Req = 1'b1;
        serve(20);

        push_rd(5'd0, 5'd5, 32'h0, 32'hFAEAFAEA);
        rdSel0 = 5'd0; rdSel1 = 5'd5; rdReq = 1'b1;
        serve(20);

        push_wr(2, 5'd9, 32'hA5A50009, 1'b0);
        wr1Sel = 5'd9; wr1Data = 32'hA5A50009; wr1Req = 1'b1;
        serve(20);

        // all three held from reset: rd, wr0, wr1, rd, wr0, wr1
        resetBar = 1'b0;
        @(negedge clk);
        resetBar = 1'b1;
        rdSel0 = 5'd9; rdSel1 = 5'd5;
        wr0Sel = 5'd3; wr0Data = 32'h33330003;
        wr1Sel = 5'd4; wr1Data = 32'h44440004;
        for (int i = 0; i < 2; i++) begin
            push_rd(5'd9, 5'd5, 32'hA5A50009, 32'hFAEAFAEA);
            push_wr(1, 5'd3, 32'h33330003, 1'b0);
            push_wr(2, 5'd4, 32'h44440004, 1'b0);
        end
        base = ack_count;
        burst_mode = 1'b1;
        rdReq = 1'b1; wr0Req = 1'b1; wr1Req = 1'b1;
        n = 0;
        while (ack_count < base + 6 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ack_count < base + 6) fail_now("burst_timeout");
        rdReq = 1'b0; wr0Req = 1'b0; wr1Req = 1'b0;
        repeat (3) @(negedge clk);
        burst_mode = 1'b0;

        // reset lands in the ACCESS cycle of a wr0 write
        wr0Sel = 5'd6; wr0Data = 32'h00000066; wr0Req = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_access_started", 32'(CSBar), 32'd0);
        resetBar = 1'b0;
        #1;
        chk("abort_csbar", 32'(CSBar), 32'd1);
        chk("abort_wr0ack", 32'(wr0Ack), 32'd0);
        chk("abort_rdwrbar", 32'(RDWRBar), 32'd1);
        rdSel0 = 5'd6; rdSel1 = 5'd5; rdReq = 1'b1;
        push_rd(5'd6, 5'd5, 32'h0, 32'hFAEAFAEA);
        push_wr(1, 5'd6, 32'h00000066, 1'b0);
        repeat (2) @(negedge clk);
        resetBar = 1'b1;
        serve(20);

        push_rd(5'd6, 5'd4, 32'h00000066, 32'h44440004);
        rdSel0 = 5'd6; rdSel1 = 5'd4; rdReq = 1'b1;
        serve(20);

        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("rdv_queue_drained", 32'(rdv_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
